writeback_module: RTL
=====================

Name: writeback_module

Overview:
- Final pipeline stage (memory access plus writeback). Accepts the execute-stage result and control bundle, and performs data-memory loads and stores over a req/ack handshake.
- Returns reg_write_en_out, reg_write_dest_out and reg_write_data_out to the decode stage's register file.
- Holds stall_out high while a memory transaction is outstanding, so upstream stages freeze.

Parameters:
- BUNDLE_W, 7, width of control bundle (bit0 reg_write_en, bit1 mem_read, bit2 mem_write, bit3 link_sel, bits5:4 size 00=word 01=half 10=byte, bit6 load_unsigned)
- ADDR_W, 32, data-memory address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- valid_in  in  1  execute stage presents an instruction
- bundle_in  in  BUNDLE_W  control bundle
- alu_result_in  in  32  ALU result or effective address
- store_data_in  in  32  rt value for stores
- pc_seq_2_in  in  32  link address (PC+8)
- reg_write_dest_in  in  5  destination register
- stall_out  out  1  upstream must hold
- mem_req_out  out  1  memory request
- mem_we_out  out  1  1=store
- mem_addr_out  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- mem_wdata_out  out  32  store data, replicated per size
- mem_be_out  out  4  byte enables
- mem_ack_in  in  1  memory completes request this cycle
- mem_rdata_in  in  32  load data, valid with ack
- reg_write_en_out  out  1  one-cycle regfile write strobe
- reg_write_dest_out  out  5  write register
- reg_write_data_out  out  32  write data
- misalign_out  out  1  one-cycle pulse on misaligned access

Behaviour:
- Reset: state IDLE. All outputs 0, including stall_out, mem_req_out, the write strobe, misalign_out, and all data/address outputs.
- States:
  - IDLE: capture allowed.
  - MEM: request outstanding.
- Capture: at a rising edge with state IDLE and valid_in=1, latch all inputs. valid_in=0 captures nothing, and no strobe follows.
- Non-memory op (mem_read=mem_write=0): in the cycle after capture, drive the write outputs.
  - reg_write_en_out = bundle reg_write_en.
  - Data = pc_seq_2 if link_sel, else alu_result.
  - Latency is 1 cycle. Back-to-back instructions give strobes on consecutive cycles.
- Memory op, aligned: IDLE→MEM. From the cycle after capture, hold mem_req_out=1 and stall_out=1, with addr/we/be/wdata stable until ack.
  - The edge that samples mem_ack_in=1 returns to IDLE, deasserts req and stall, and registers rdata.
  - Load: write strobe in the cycle after ack.
  - Store: no write strobe.
  - Ack while in IDLE is ignored.
- Byte lanes are little-endian; lane = addr[1:0].
  - Word: be=1111, wdata=store_data.
  - Half: be=0011 or 1100 (by addr[1]), wdata={2{sd[15:0]}}.
  - Byte: be=0001<<addr[1:0], wdata={4{sd[7:0]}}.
- Load extraction: select the lane(s), then zero-extend if load_unsigned, else sign-extend.
- Misaligned access (word with addr[1:0]≠0, half with addr[0]=1): no request, state stays IDLE, misalign_out pulses in the cycle after capture, no write strobe.
- Register 0: reg_write_en_out is forced 0 when dest=0; data and dest are still driven.
- Size 11 is treated as word.
- Outside its pulse, reg_write_en_out=0; dest/data hold their last values.
- Reset during MEM: drop req immediately at that edge, return to IDLE, suppress any pending strobe. A late ack is ignored.
- Simultaneous ack and new valid_in: the new instruction is not captured at that edge (stall still 1). It is captured at the next edge.

Optional Feature:
- Macro: WB_SUBWORD_EN.
- Defined: half/byte loads and stores, sign/zero extension and half misalignment checks exactly as above.
- Undefined: size bits ignored; all accesses are word (be=1111, no lane extraction); only word misalignment checked; load_unsigned ignored.

Test Plan:
- ALU op: valid, alu_result=0x0000_1234, dest=8, reg_write_en=1 → next cycle strobe=1, dest=8, data=0x1234; no mem_req.
- Link: link_sel=1, pc_seq_2=0x0040_0008, dest=31 → next cycle data=0x0040_0008, dest=31.
- Word load addr=0x100, ack after 3 wait cycles with rdata=0xDEAD_BEEF → req/stall high 4 cycles, addr=0x100, then strobe data=0xDEADBEEF.
- Byte load signed addr=0x103, rdata=0x80FF_FFFF → data=0xFFFF_FF80. Same with unsigned → 0x0000_0080. Byte store sd=0xAB at 0x102 → be=0100, wdata=0xABAB_ABAB, no strobe.
- Misaligned word at 0x102 → misalign_out pulse, no req, no strobe. Dest=0 ALU op → strobe 0.
- Reset asserted mid-MEM → next cycle req=0, stall=0; following ack ignored; no strobe.

Source files
------------

// File: rtl/writeback_module.sv
// writeback_module: final pipeline stage (data-memory access plus register writeback).
// Non-memory results are written back one cycle after capture. Loads and stores run a
// req/ack transaction while stall_out freezes the upstream stages.
// Build option: define WB_SUBWORD_EN to enable half/byte accesses with sign/zero extension.
// Without it every access is a full word and only word alignment is checked.
module writeback_module #(
    parameter int BUNDLE_W = 7,
    parameter int ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [BUNDLE_W-1:0] bundle_in,
    input  logic [31:0]         alu_result_in,
    input  logic [31:0]         store_data_in,
    input  logic [31:0]         pc_seq_2_in,
    input  logic [4:0]          reg_write_dest_in,
    output logic                stall_out,
    output logic                mem_req_out,
    output logic                mem_we_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic [31:0]         mem_wdata_out,
    output logic [3:0]          mem_be_out,
    input  logic                mem_ack_in,
    input  logic [31:0]         mem_rdata_in,
    output logic                reg_write_en_out,
    output logic [4:0]          reg_write_dest_out,
    output logic [31:0]         reg_write_data_out,
    output logic                misalign_out
);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [0:0] {IDLE = 1'b0, MEM = 1'b1} state_t;

    state_t      state;
    state_t      state_next;

    logic        is_load;
    logic        is_mem;
    logic        capture;
    logic        misaligned;
    logic        mem_go;
    logic        ack_take;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        load_unsigned;

    // load context held across the memory transaction
    logic        wen_p1;
    logic        load_p1;
    logic [4:0]  dest_p1;
    logic [1:0]  size_p1;
    logic [1:0]  lane_p1;
    logic        uns_p1;

    // Size 11 falls into the default (word) branch of every helper below.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] ln);
        case (sz)
            SZ_HALF: is_misaligned = ln[0];
            SZ_BYTE: is_misaligned = 1'b0;
            default: is_misaligned = |ln;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] ln);
        case (sz)
            SZ_HALF: lane_be = ln[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: lane_be = 4'b0001 << ln;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] sd);
        case (sz)
            SZ_HALF: lane_wdata = {2{sd[15:0]}};
            SZ_BYTE: lane_wdata = {4{sd[7:0]}};
            default: lane_wdata = sd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] ln,
                                                 input logic uns, input logic [31:0] rdata);
        logic signed [15:0] half_s;
        logic signed [7:0]  byte_s;
        logic signed [31:0] ext;
        half_s = ln[1] ? rdata[31:16] : rdata[15:0];
        byte_s = rdata[{ln, 3'b000} +: 8];
        case (sz)
            SZ_HALF: begin
                ext = 32'(half_s);
                if (uns) ext[31:16] = '0;
            end
            SZ_BYTE: begin
                ext = 32'(byte_s);
                if (uns) ext[31:8] = '0;
            end
            default: ext = rdata;
        endcase
        load_extract = ext;
    endfunction

    // mem_write wins if both memory bits are set, so a load is read-only.
    assign is_load = bundle_in[1] & ~bundle_in[2];
    assign is_mem  = bundle_in[1] | bundle_in[2];
    assign lane    = alu_result_in[1:0];

`ifdef WB_SUBWORD_EN
    assign size          = bundle_in[5:4];
    assign load_unsigned = bundle_in[6];
`else
    // Size and signedness bits are don't-care when only word accesses exist.
    logic unused_subword_bits;
    assign unused_subword_bits = ^bundle_in[6:4];
    assign size          = SZ_WORD;
    assign load_unsigned = 1'b0;
`endif

    assign capture    = (state == IDLE) && valid_in;
    assign misaligned = is_misaligned(size, lane);
    assign mem_go     = capture && is_mem && !misaligned;
    assign ack_take   = (state == MEM) && mem_ack_in;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next state: enter MEM on an aligned memory op, leave on ack
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_go) state_next = MEM;
            MEM:     if (mem_ack_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // request and stall are high for exactly the cycles spent in MEM
    always_comb begin
        mem_req_out = (state == MEM);
        stall_out   = (state == MEM);
    end

    // transaction fields, frozen for the whole outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            mem_be_out    <= '0;
        end else if (mem_go) begin
            mem_we_out    <= bundle_in[2];
            mem_addr_out  <= {alu_result_in[ADDR_W-1:2], 2'b00};
            mem_wdata_out <= lane_wdata(size, store_data_in);
            mem_be_out    <= lane_be(size, lane);
        end
    end

    // ---- stage p1: capture load context for use when the ack arrives ----
    always_ff @(posedge clk) begin
        if (capture) begin
            wen_p1  <= bundle_in[0] && (reg_write_dest_in != 5'd0);
            load_p1 <= is_load;
            dest_p1 <= reg_write_dest_in;
            size_p1 <= size;
            lane_p1 <= lane;
            uns_p1  <= load_unsigned;
        end
    end

    // ---- writeback outputs: strobe and misalign are single-cycle pulses ----
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_en_out   <= 1'b0;
            reg_write_dest_out <= '0;
            reg_write_data_out <= '0;
            misalign_out       <= 1'b0;
        end else begin
            reg_write_en_out <= 1'b0;
            misalign_out     <= 1'b0;
            if (capture && !is_mem) begin
                reg_write_en_out   <= bundle_in[0] && (reg_write_dest_in != 5'd0);
                reg_write_dest_out <= reg_write_dest_in;
                reg_write_data_out <= bundle_in[3] ? pc_seq_2_in : alu_result_in;
            end else if (capture && misaligned) begin
                misalign_out <= 1'b1;
            end else if (ack_take && load_p1) begin
                reg_write_en_out   <= wen_p1;
                reg_write_dest_out <= dest_p1;
                reg_write_data_out <= load_extract(size_p1, lane_p1, uns_p1, mem_rdata_in);
            end
        end
    end

endmodule
